// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
//   Shared definitions for the DMA register-port arbiter: the addresses of the
//   four DMA registers that form the accessible window, and the arbiter FSM
//   state encoding.
// -----------------------------------------------------------------------------
package dma_pkg;

    localparam logic [31:0] DMA_INTR_ADDR = 32'h0000_0400;
    localparam logic [31:0] DMA_CTRL_ADDR = 32'h0000_0404;
    localparam logic [31:0] DMA_IO_ADDR   = 32'h0000_0408;
    localparam logic [31:0] DMA_MEM_ADDR  = 32'h0000_040C;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin pick. Scans the request vector starting
//   at ptr_i and wrapping modulo N; the first set bit wins.
// Ports
//   req_i    in   N     request vector
//   ptr_i    in   IW    scan start position (0..N-1)
//   grant_o  out  N     one-hot grant (all zero when no request)
//   idx_o    out  IW    index of the granted requester (0 when no request)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o
);

    logic        found;
    int unsigned j;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr_i) + k) % N;
            if (!found && req_i[j[IW-1:0]]) begin
                found               = 1'b1;
                grant_o[j[IW-1:0]]  = 1'b1;
                idx_o               = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/dma_reg_arbiter.sv
// -----------------------------------------------------------------------------
// dma_reg_arbiter
//   Shares the DMA register port between NUM_REQ requesters. One request is
//   accepted at a time (round-robin), its address is checked against the DMA
//   register window, a single-cycle valid pulse is issued to the DMA, and a
//   one-cycle response (write ack, read data or address error) is returned to
//   the winning requester.
// Ports
//   clk, reset_n             clock, async active-low reset
//   req_valid/req_wr         per-requester request and direction (1=write)
//   req_addr/req_wdata       flattened per-requester address / write data
//   req_ready                one-hot accept strobe, only while idle
//   rsp_valid/rsp_err        one-hot response pulse, address-error flag
//   rsp_rdata                read data (0 for writes and errors)
//   dma_addr/wr_en/valid/wdata  registered DMA command outputs
//   dma_rdata                DMA read data, valid the cycle after the pulse
//   busy                     a transaction is in flight
// -----------------------------------------------------------------------------
module dma_reg_arbiter
    import dma_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic                          rsp_err,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [ADDR_WIDTH-1:0]         dma_addr,
    output logic                          dma_wr_en,
    output logic                          dma_valid,
    output logic [DATA_WIDTH-1:0]         dma_wdata,
    input  logic [DATA_WIDTH-1:0]         dma_rdata,
    output logic                          busy
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e             state_q, state_d;
    logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]          id_q, id_d;
    logic                   err_q, err_d;
    logic [ADDR_WIDTH-1:0]  dma_addr_q, dma_addr_d;
    logic                   dma_wr_en_q, dma_wr_en_d;
    logic                   dma_valid_q, dma_valid_d;
    logic [DATA_WIDTH-1:0]  dma_wdata_q, dma_wdata_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;

    logic [NUM_REQ-1:0]     grant;
    logic [IW-1:0]          win_idx;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic                   sel_wr;
    logic                   addr_ok;

    rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (win_idx)
    );

    assign sel_addr  = req_addr[32'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = req_wdata[32'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_wr    = req_wr[win_idx];

    // Only the four aligned register addresses are legal; anything else,
    // including unaligned addresses inside the window, is an error.
    assign addr_ok = sel_addr inside {ADDR_WIDTH'(DMA_INTR_ADDR), ADDR_WIDTH'(DMA_CTRL_ADDR),
                                      ADDR_WIDTH'(DMA_IO_ADDR),   ADDR_WIDTH'(DMA_MEM_ADDR)};

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        err_d       = err_q;
        dma_addr_d  = dma_addr_q;
        dma_wr_en_d = dma_wr_en_q;
        dma_valid_d = 1'b0;
        dma_wdata_d = dma_wdata_q;
        rdata_d     = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    id_d     = win_idx;
                    rr_ptr_d = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    rdata_d  = '0;
                    if (addr_ok) begin
                        err_d       = 1'b0;
                        dma_addr_d  = sel_addr;
                        dma_wr_en_d = sel_wr;
                        dma_wdata_d = sel_wdata;
                        dma_valid_d = 1'b1;
                        state_d     = ISSUE;
                    end else begin
                        // DMA command registers keep their last values.
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ISSUE:   state_d = dma_wr_en_q ? RESP : CAPTURE;
            CAPTURE: begin
                rdata_d = dma_rdata;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            err_q       <= 1'b0;
            dma_addr_q  <= '0;
            dma_wr_en_q <= 1'b0;
            dma_valid_q <= 1'b0;
            dma_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            err_q       <= err_d;
            dma_addr_q  <= dma_addr_d;
            dma_wr_en_q <= dma_wr_en_d;
            dma_valid_q <= dma_valid_d;
            dma_wdata_q <= dma_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign req_ready = (state_q == IDLE) ? grant : '0;
    assign rsp_valid = (state_q == RESP) ? (NUM_REQ'(1) << id_q) : '0;
    assign rsp_err   = (state_q == RESP) && err_q;
    assign rsp_rdata = (state_q == RESP) ? rdata_q : '0;
    assign dma_addr  = dma_addr_q;
    assign dma_wr_en = dma_wr_en_q;
    assign dma_valid = dma_valid_q;
    assign dma_wdata = dma_wdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dma_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dma_reg_arbiter
//   Self-checking bench for dma_reg_arbiter with a behavioural DMA register
//   file. Expected responses are queued when a request is accepted and are
//   compared (id, error, data, latency) when the response pulse appears.
// -----------------------------------------------------------------------------
module tb_dma_reg_arbiter;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [3:0]    req_valid = '0;
    logic [3:0]    req_wr = '0;
    logic [127:0]  req_addr = '0;
    logic [127:0]  req_wdata = '0;
    logic [3:0]    req_ready;
    logic [3:0]    rsp_valid;
    logic          rsp_err;
    logic [31:0]   rsp_rdata;
    logic [31:0]   dma_addr;
    logic          dma_wr_en;
    logic          dma_valid;
    logic [31:0]   dma_wdata;
    logic [31:0]   dma_rdata = '0;
    logic          busy;

    dma_reg_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .dma_addr  (dma_addr),
        .dma_wr_en (dma_wr_en),
        .dma_valid (dma_valid),
        .dma_wdata (dma_wdata),
        .dma_rdata (dma_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // DMA register file: registers rdata on the pulse edge.
    logic [31:0] dma_regs [4] = '{default: 32'h0};
    always @(posedge clk) begin
        if (dma_valid) begin
            if (dma_wr_en) dma_regs[dma_addr[3:2]] <= dma_wdata;
            else           dma_rdata <= dma_regs[dma_addr[3:2]];
        end
    end

    typedef struct {
        int unsigned id;
        logic        err;
        logic [31:0] rdata;
        int unsigned due;
    } exp_t;

    typedef struct {
        int unsigned id;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    exp_t        sb[$];
    int unsigned acc_q[$];
    int unsigned acc_cyc [4];
    logic        pend_err [4];
    logic        pend_wr [4];
    logic [31:0] pend_addr [4];
    logic [31:0] pend_wdata [4];
    logic [31:0] pend_rdata [4];
    logic [31:0] shadow [4] = '{default: 32'h0};
    vec_t        vecs [11];

    int unsigned cyc = 0;
    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned pulses = 0;
    int unsigned exp_pulses = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic addr_ok(input logic [31:0] a);
        return (a == 32'h400) || (a == 32'h404) || (a == 32'h408) || (a == 32'h40C);
    endfunction

    task automatic post(input int unsigned id, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic err, input logic [31:0] rdata);
        req_wr[id]             = wr;
        req_addr[id*32 +: 32]  = addr;
        req_wdata[id*32 +: 32] = wdata;
        pend_err[id]   = err;
        pend_wr[id]    = wr;
        pend_addr[id]  = addr;
        pend_wdata[id] = wdata;
        pend_rdata[id] = rdata;
        req_valid[id]  = 1'b1;
    endtask

    // Expectations taken from the bench's own model of the register file.
    task automatic post_m(input int unsigned id, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata);
        logic e;
        e = !addr_ok(addr);
        post(id, wr, addr, wdata, e, (e || wr) ? 32'h0 : shadow[addr[3:2]]);
    endtask

    // One clock: sample at negedge, update inputs just after the posedge.
    task automatic step();
        logic [3:0]  acc_m;
        int unsigned lat;
        exp_t        e;
        acc_m = '0;
        @(negedge clk);
        if (rsp_valid != 4'b0) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got rsp_valid=%b expected none", rsp_valid);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", 64'(rsp_valid), 64'(1) << e.id);
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                chk("rsp_latency", 64'(cyc), 64'(e.due));
            end
        end else if (sb.size() > 0 && cyc > sb[0].due) begin
            tests++;
            fails++;
            $display("FAIL rsp_missing: got no response expected id %0d by cycle %0d", sb[0].id, sb[0].due);
            void'(sb.pop_front());
        end
        if (busy) chk("ready_while_busy", 64'(req_ready), 64'h0);
        if (dma_valid) pulses++;
        for (int unsigned i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                acc_m[i] = 1'b1;
                lat = pend_err[i] ? 1 : (pend_wr[i] ? 2 : 3);
                sb.push_back('{i, pend_err[i], pend_rdata[i], cyc + lat});
                if (!pend_err[i]) begin
                    exp_pulses++;
                    if (pend_wr[i]) shadow[pend_addr[i][3:2]] = pend_wdata[i];
                end
                acc_q.push_back(i);
                acc_cyc[i] = cyc;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        req_valid = req_valid & ~acc_m;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            step();
            done = (sb.size() == 0) && (req_valid == 4'b0) && !busy;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got pending=%0d expected 0", name, sb.size());
            sb.delete();
            req_valid = '0;
        end
    endtask

    task automatic wait_accept(input int unsigned n, input string name);
        for (int k = 0; k < 10 && acc_q.size() < n; k++) step();
        if (acc_q.size() < n) begin
            tests++;
            fails++;
            $display("FAIL %s_accept_timeout: got %0d accepts expected %0d", name, acc_q.size(), n);
        end
    endtask

    initial begin
        vecs[0]  = '{0, 1'b1, 32'h404, 32'hA5A5_0001, 1'b0, 32'h0};
        vecs[1]  = '{1, 1'b0, 32'h404, 32'h0,         1'b0, 32'hA5A5_0001};
        vecs[2]  = '{2, 1'b1, 32'h410, 32'h5555_5555, 1'b1, 32'h0};
        vecs[3]  = '{2, 1'b0, 32'h402, 32'h0,         1'b1, 32'h0};
        vecs[4]  = '{3, 1'b1, 32'h40C, 32'h1234_5678, 1'b0, 32'h0};
        vecs[5]  = '{0, 1'b0, 32'h40C, 32'h0,         1'b0, 32'h1234_5678};
        vecs[6]  = '{1, 1'b1, 32'h400, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[7]  = '{2, 1'b0, 32'h400, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[8]  = '{3, 1'b0, 32'h408, 32'h0,         1'b0, 32'h1000_0002};
        vecs[9]  = '{0, 1'b1, 32'h3FC, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[10] = '{1, 1'b0, 32'h40D, 32'h0,         1'b1, 32'h0};

        // Reset state
        repeat (2) step();
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_dma_valid", 64'(dma_valid), 64'h0);
        chk("reset_dma_addr", 64'(dma_addr), 64'h0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
        reset_n = 1'b1;
        step();

        // All four requesters at once from reset, then 3+0 after wrap
        for (int unsigned i = 0; i < 4; i++) post_m(i, 1'b1, 32'h400 + 4 * i, 32'h1000_0000 + i);
        drain("rr_all");
        chk("rr_count", 64'(acc_q.size()), 64'd4);
        for (int unsigned i = 0; i < 4 && i < acc_q.size(); i++) chk("rr_order", 64'(acc_q[i]), 64'(i));
        acc_q.delete();
        post_m(3, 1'b0, 32'h40C, 32'h0);
        post_m(0, 1'b0, 32'h400, 32'h0);
        drain("rr_wrap");
        chk("wrap_count", 64'(acc_q.size()), 64'd2);
        if (acc_q.size() == 2) begin
            chk("wrap_first", 64'(acc_q[0]), 64'd0);
            chk("wrap_second", 64'(acc_q[1]), 64'd3);
        end

        // Table-driven single transactions
        for (int unsigned v = 0; v < 11; v++) begin
            post(vecs[v].id, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].exp_err, vecs[v].exp_rdata);
            drain("vec");
        end
        chk("dma_pulses", 64'(pulses), 64'(exp_pulses));

        // Request arriving while busy waits, then is accepted at T+3
        acc_q.delete();
        post_m(0, 1'b1, 32'h400, 32'h0BAD_F00D);
        wait_accept(1, "busy0");
        chk("issue_dma_valid", 64'(dma_valid), 64'h1);
        chk("issue_dma_wr_en", 64'(dma_wr_en), 64'h1);
        chk("issue_dma_addr", 64'(dma_addr), 64'h400);
        chk("issue_dma_wdata", 64'(dma_wdata), 64'h0BAD_F00D);
        post_m(1, 1'b0, 32'h400, 32'h0);
        drain("busy");
        if (acc_q.size() == 2) begin
            chk("busy_order", 64'(acc_q[1]), 64'd1);
            chk("busy_accept_gap", 64'(acc_cyc[1] - acc_cyc[0]), 64'd3);
        end else begin
            chk("busy_count", 64'(acc_q.size()), 64'd2);
        end

        // Reset during ISSUE drops the transaction and rr_ptr
        acc_q.delete();
        post_m(2, 1'b0, 32'h404, 32'h0);
        wait_accept(1, "rst");
        chk("rst_pre_dma_valid", 64'(dma_valid), 64'h1);
        reset_n   = 1'b0;
        req_valid = '0;
        #1;
        chk("rst_dma_valid_async", 64'(dma_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_dma_addr", 64'(dma_addr), 64'h0);
        sb.delete();
        pulses = 0;
        exp_pulses = 0;
        repeat (2) step();
        reset_n = 1'b1;
        acc_q.delete();
        post_m(3, 1'b0, 32'h408, 32'h0);
        post_m(1, 1'b0, 32'h40C, 32'h0);
        drain("post_rst");
        if (acc_q.size() == 2) begin
            chk("post_rst_first", 64'(acc_q[0]), 64'd1);
            chk("post_rst_second", 64'(acc_q[1]), 64'd3);
        end else begin
            chk("post_rst_count", 64'(acc_q.size()), 64'd2);
        end
        chk("post_rst_pulses", 64'(pulses), 64'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
